// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks start/data/parity/stop slots, runs the oversample
// edge counter and data bit counter, and strobes the sampler, deserializer and checkers.
`timescale 1ns / 1ps

module uart_rx_ctrl #(
   parameter int unsigned DATA_W = 8,
   localparam int unsigned BIT_W = $clog2(DATA_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             RX_IN,
   input  logic             PAR_EN,
   input  logic [5:0]       Prescale,
   input  logic             strt_glitch,
   input  logic             par_err,
   input  logic             stp_err,
   output logic [5:0]       edge_cnt,
   output logic [BIT_W-1:0] bit_cnt,
   output logic             data_samp_en,
   output logic             deser_en,
   output logic             strt_chk_en,
   output logic             par_chk_en,
   output logic             stp_chk_en,
   output logic             data_valid,
   output logic             par_err_o,
   output logic             stp_err_o
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StDone
   } t_state;

   localparam logic [BIT_W-1:0] LastBit = BIT_W'(DATA_W - 1);

   t_state           r_state;
   t_state           w_state_nxt;
   logic [5:0]       r_ps;
   logic [5:0]       w_ps_nxt;
   logic [5:0]       r_edge_cnt;
   logic [5:0]       w_edge_cnt_nxt;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [BIT_W-1:0] w_bit_cnt_nxt;
   logic             r_par_err;
   logic             w_par_err_nxt;
   logic             r_stp_err;
   logic             w_stp_err_nxt;
   logic             w_end_of_bit;
   logic             w_frame_start;
   logic             w_last_bit;

   // ps == 0 makes ps-1 == 63, so the counter simply wraps at 63 instead of locking up
   assign w_end_of_bit  = (r_state != StIdle) && (r_edge_cnt == (r_ps - 6'd1));
   assign w_frame_start = (r_state == StIdle) && !RX_IN;
   assign w_last_bit    = (r_bit_cnt == LastBit);

   // Next-state decision for the frame sequencer
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (!RX_IN) w_state_nxt = StStart;
         end
         StStart: begin
            if (w_end_of_bit) w_state_nxt = strt_glitch ? StIdle : StData;
         end
         StData: begin
            // PAR_EN is only looked at here, so toggling it mid-frame is harmless
            if (w_end_of_bit && w_last_bit) w_state_nxt = PAR_EN ? StParity : StStop;
         end
         StParity: begin
            if (w_end_of_bit) w_state_nxt = StStop;
         end
         StStop: begin
            if (w_end_of_bit) w_state_nxt = StDone;
         end
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // Next values for prescale latch, counters and sticky error flags
   always_comb begin
      w_ps_nxt       = r_ps;
      w_edge_cnt_nxt = r_edge_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_par_err_nxt  = r_par_err;
      w_stp_err_nxt  = r_stp_err;

      // Prescale is frozen for the whole frame; flags restart with each frame
      if (w_frame_start) begin
         w_ps_nxt      = Prescale;
         w_par_err_nxt = 1'b0;
         w_stp_err_nxt = 1'b0;
      end

      if ((r_state == StIdle) || (w_state_nxt == StIdle) || w_end_of_bit) begin
         w_edge_cnt_nxt = 6'd0;
      end else begin
         w_edge_cnt_nxt = r_edge_cnt + 6'd1;
      end

      if (r_state == StIdle) begin
         w_bit_cnt_nxt = '0;
      end else if ((r_state == StStart) && w_end_of_bit) begin
         w_bit_cnt_nxt = '0;
      end else if ((r_state == StData) && w_end_of_bit && !w_last_bit) begin
         w_bit_cnt_nxt = r_bit_cnt + 1'b1;
      end

      // Checker results are only trusted on the end_of_bit edge
      if ((r_state == StParity) && w_end_of_bit) begin
         w_par_err_nxt = r_par_err | par_err;
      end
      if ((r_state == StStop) && w_end_of_bit) begin
         w_stp_err_nxt = r_stp_err | stp_err;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath registers: prescale latch, counters, sticky error flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ps       <= 6'd0;
         r_edge_cnt <= 6'd0;
         r_bit_cnt  <= '0;
         r_par_err  <= 1'b0;
         r_stp_err  <= 1'b0;
      end else begin
         r_ps       <= w_ps_nxt;
         r_edge_cnt <= w_edge_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_par_err  <= w_par_err_nxt;
         r_stp_err  <= w_stp_err_nxt;
      end
   end

   // Enables and strobes decoded from the current state
   always_comb begin
      data_samp_en = 1'b0;
      deser_en     = 1'b0;
      strt_chk_en  = 1'b0;
      par_chk_en   = 1'b0;
      stp_chk_en   = 1'b0;
      data_valid   = 1'b0;
      unique case (r_state)
         StIdle: begin
         end
         StStart: begin
            data_samp_en = 1'b1;
            strt_chk_en  = 1'b1;
         end
         StData: begin
            data_samp_en = 1'b1;
            deser_en     = w_end_of_bit;
         end
         StParity: begin
            data_samp_en = 1'b1;
            par_chk_en   = 1'b1;
         end
         StStop: begin
            data_samp_en = 1'b1;
            stp_chk_en   = 1'b1;
         end
         StDone: begin
            // Flags already include whatever was captured on the stop-bit edge
            data_valid = !r_par_err && !r_stp_err;
         end
         default: begin
         end
      endcase
   end

   assign edge_cnt  = r_edge_cnt;
   assign bit_cnt   = r_bit_cnt;
   assign par_err_o = r_par_err;
   assign stp_err_o = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames and checks every cycle against
// a slot/edge model derived from the frame position.
`timescale 1ns / 1ps

module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       RX_IN;
   logic       PAR_EN;
   logic [5:0] Prescale;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [5:0] edge_cnt;
   logic [2:0] bit_cnt;
   logic       data_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       par_err_o;
   logic       stp_err_o;

   int n_checks = 0;
   int n_errors = 0;
   int g_dv_c   = -1;

   uart_rx_ctrl #(.DATA_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .RX_IN       (RX_IN),
      .PAR_EN      (PAR_EN),
      .Prescale    (Prescale),
      .strt_glitch (strt_glitch),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .data_samp_en(data_samp_en),
      .deser_en    (deser_en),
      .strt_chk_en (strt_chk_en),
      .par_chk_en  (par_chk_en),
      .stp_chk_en  (stp_chk_en),
      .data_valid  (data_valid),
      .par_err_o   (par_err_o),
      .stp_err_o   (stp_err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [5:0] en_vec();
      return {data_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid};
   endfunction

   // Idle cycles with the line high: everything quiet, flags held
   task automatic idle_hold(input int n, input logic [1:0] flags);
      for (int i = 0; i < n; i++) begin
         check("hold_en", 32'(en_vec()), 32'd0);
         check("hold_edge", 32'(edge_cnt), 32'd0);
         check("hold_flags", 32'({par_err_o, stp_err_o}), 32'(flags));
         @(negedge clk);
      end
   endtask

   // One frame; cycle c=0 is the first START cycle. ps_mid>=0 switches Prescale to 16 at
   // that cycle; rst_slot>=0 fires an async reset at edge 2 of that slot and returns.
   task automatic run_frame(input int ps, input logic par, input logic [7:0] data,
                            input logic glitch, input logic perr, input logic serr,
                            input int ps_mid, input int rst_slot);
      int         p;
      int         last_c;
      int         slot;
      int         e;
      int         n_deser;
      int         n_dv;
      logic       pe;
      logic       eob;
      logic       noise;
      logic [5:0] exp_en;
      logic [1:0] exp_flags;
      logic [5:0] exp_edge;

      p       = par ? 1 : 0;
      pe      = par & perr;
      last_c  = glitch ? ps - 1 : (10 + p) * ps;
      n_deser = 0;
      n_dv    = 0;
      g_dv_c  = -1;
      Prescale    = 6'(ps);
      PAR_EN      = par;
      RX_IN       = 1'b0;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
      @(negedge clk);
      for (int c = 0; c <= last_c + 1; c++) begin
         slot = c / ps;
         e    = c % ps;
         if (c > last_c) begin
            exp_edge  = 6'd0;
            exp_en    = 6'd0;
            exp_flags = glitch ? 2'b00 : {pe, serr};
         end else if (!glitch && c == last_c) begin
            exp_edge  = 6'd0;
            exp_en    = {5'b0, !(pe || serr)};
            exp_flags = {pe, serr};
         end else begin
            exp_edge  = 6'(e);
            exp_en    = {1'b1, (slot >= 1 && slot <= 8 && e == ps - 1), (slot == 0),
                         (par && slot == 9), (slot == 9 + p), 1'b0};
            exp_flags = {(par && c >= 10 * ps) ? pe : 1'b0, 1'b0};
         end
         check("edge", 32'(edge_cnt), 32'(exp_edge));
         check("en", 32'(en_vec()), 32'(exp_en));
         check("flags", 32'({par_err_o, stp_err_o}), 32'(exp_flags));
         if (c <= last_c && slot >= 1 && slot <= 8) check("bit", 32'(bit_cnt), 32'(slot - 1));
         if (deser_en) n_deser++;
         if (data_valid) begin
            n_dv++;
            g_dv_c = c;
         end

         if (rst_slot >= 0 && slot == rst_slot && e == 2) begin
            #1 reset = 1'b1;
            #1;
            check("rst_edge", 32'(edge_cnt), 32'd0);
            check("rst_bit", 32'(bit_cnt), 32'd0);
            check("rst_en", 32'(en_vec()), 32'd0);
            check("rst_flags", 32'({par_err_o, stp_err_o}), 32'd0);
            RX_IN = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check("rst_idle_en", 32'(en_vec()), 32'd0);
            return;
         end

         // Inputs for the edge that ends cycle c
         eob   = (e == ps - 1);
         noise = (e == 1);
         if (c >= last_c) RX_IN = 1'b1;
         else if (slot == 0) RX_IN = 1'b0;
         else if (slot <= 8) RX_IN = data[slot-1];
         else if (par && slot == 9) RX_IN = ^data;
         else RX_IN = 1'b1;
         strt_glitch = (c <= last_c && slot == 0) ? (eob ? glitch : noise) : 1'b0;
         par_err     = (!glitch && par && slot == 9) ? (eob ? perr : noise) : 1'b0;
         stp_err     = (!glitch && slot == 9 + p && c < last_c) ? (eob ? serr : noise) : 1'b0;
         if (ps_mid >= 0 && c == ps_mid) Prescale = 6'd16;
         @(negedge clk);
      end
      check("n_deser", 32'(n_deser), glitch ? 32'd0 : 32'd8);
      check("n_dv", 32'(n_dv), (!glitch && !pe && !serr) ? 32'd1 : 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      RX_IN       = 1'b1;
      PAR_EN      = 1'b0;
      Prescale    = 6'd8;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_edge", 32'(edge_cnt), 32'd0);
      check("reset_bit", 32'(bit_cnt), 32'd0);
      check("reset_en", 32'(en_vec()), 32'd0);
      check("reset_flags", 32'({par_err_o, stp_err_o}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      idle_hold(2, 2'b00);

      // Prescale 8, no parity, 0xA5: DONE 80 cycles after START entry (81 after fall edge)
      run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
      check("dv_lat", 32'(g_dv_c), 32'd80);

      // Prescale 16 with parity error; flag holds through idle then clears on next START
      run_frame(16, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, -1, -1);
      idle_hold(5, 2'b10);
      run_frame(16, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, -1, -1);
      check("dv_lat_par", 32'(g_dv_c), 32'd176);

      // Start glitch abort at prescale 32, then immediate restart
      run_frame(32, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, -1, -1);

      // Stop error, then a clean 0x3C back-to-back
      run_frame(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, -1, -1);
      run_frame(8, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);

      // Reset in DATA at bit_cnt=4, then a clean frame
      run_frame(8, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, 5);
      idle_hold(2, 2'b00);
      run_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, -1, -1);

      // Prescale changes 8->16 mid-frame: frame stays at 8, next frame runs at 16
      run_frame(8, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 20, -1);
      check("dv_lat_ps8", 32'(g_dv_c), 32'd80);
      run_frame(16, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, -1, -1);
      check("dv_lat_ps16", 32'(g_dv_c), 32'd160);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
